barrel_shift_req_stage: RTL

//  Request/response stage wrapped around the combinational 8-bit barrel shifter.
//  - Buffers incoming {data, shift amount} requests in a small FIFO.
//  - Presents the FIFO head to the shifter's data/amount inputs.
//  - Registers the shifter output and returns it over a valid/ready interface.
//  - Decouples producers and consumers from the shifter's combinational path.

---
 rtl/barrel_shift_req_stage_if.sv | 28 ++
 rtl/barrel_shift_req_stage.sv | 58 +++++
 2 files changed

// File: rtl/barrel_shift_req_stage_if.sv
// barrel_shift_req_stage_if: request, shifter-side and response signals of barrel_shift_req_stage
interface barrel_shift_req_stage_if #(
    parameter int DATA_W = 8,
    parameter int AMT_W  = 3,
    parameter int DEPTH  = 4
);
    logic                       flush;
    logic                       in_valid;
    logic                       in_ready;
    logic [DATA_W-1:0]          in_data;
    logic [AMT_W-1:0]           in_amt;
    logic [DATA_W-1:0]          shf_data;
    logic [AMT_W-1:0]           shf_amt;
    logic [DATA_W-1:0]          shf_result;
    logic                       out_valid;
    logic                       out_ready;
    logic [DATA_W-1:0]          out_data;
    logic [AMT_W-1:0]           out_amt;
    logic [$clog2(DEPTH):0]     level;
    modport slave (
        input  flush, in_valid, in_data, in_amt, shf_result, out_ready,
        output in_ready, shf_data, shf_amt, out_valid, out_data, out_amt, level
    );
    modport master (
        output flush, in_valid, in_data, in_amt, shf_result, out_ready,
        input  in_ready, shf_data, shf_amt, out_valid, out_data, out_amt, level
    );
endinterface

// File: rtl/barrel_shift_req_stage.sv
// barrel_shift_req_stage: request FIFO feeding an external combinational barrel shifter,
// with the shifter result registered and returned over valid/ready.
module barrel_shift_req_stage #(
    parameter int DATA_W = 8,
    parameter int AMT_W  = 3,
    parameter int DEPTH  = 4
) (
    input logic clk,
    input logic rst,
    barrel_shift_req_stage_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
    logic [DATA_W+AMT_W-1:0] r_mem [DEPTH];
    logic [PW-1:0]           r_wptr, r_rptr;
    logic [PW:0]             r_level;
    logic                    r_out_valid;
    logic [DATA_W-1:0]       r_out_data;
    logic [AMT_W-1:0]        r_out_amt;
    logic                    w_empty, w_push, w_pop;
    assign w_empty      = r_level == '0;
    assign bus.in_ready = (r_level != FULL) & ~bus.flush;
    assign w_push       = bus.in_valid & bus.in_ready;
    assign w_pop        = ~w_empty & (~r_out_valid | bus.out_ready) & ~bus.flush;
    // head is forced to zero when empty so the shifter sees a quiet input
    assign {bus.shf_data, bus.shf_amt} = w_empty ? '0 : r_mem[r_rptr];
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_amt   = r_out_amt;
    assign bus.level     = r_level;
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= {bus.in_data, bus.in_amt};
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_level     <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_amt   <= '0;
        end else if (bus.flush) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_level     <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PW'(1);
            if (w_pop) begin
                r_rptr     <= r_rptr + PW'(1);
                r_out_data <= bus.shf_result;
                r_out_amt  <= bus.shf_amt;
            end
            r_level     <= r_level + (PW+1)'(w_push) - (PW+1)'(w_pop);
            r_out_valid <= w_pop | (r_out_valid & ~bus.out_ready);
        end
    end
endmodule
